delay_mem_arbiter: RTL
======================

DELAY_MEM_ARBITER -- requirements
Module: delay_mem_arbiter

Interface
REQ-001 SHALL have parameter NR_OF_CLIENTS_P, default 2, number of requesting delay-line cores (2..8).
REQ-002 SHALL have parameter MEM_ADDR_WIDTH_P, default 32, AXI4 address width.
REQ-003 SHALL have parameter MEM_DATA_WIDTH_P, default 128, AXI4 data width.
REQ-004 SHALL have parameter AXI4_ID_P, default 0, ID driven on awid/arid.
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req  input  NR_OF_CLIENTS_P  per-client request, held high until ack.
REQ-008 SHALL have port req_wr  input  NR_OF_CLIENTS_P  per-client direction, 1=write, 0=read.
REQ-009 SHALL have port req_addr  input  NR_OF_CLIENTS_P x MEM_ADDR_WIDTH_P  per-client byte address.
REQ-010 SHALL have port req_wdata  input  NR_OF_CLIENTS_P x MEM_DATA_WIDTH_P  per-client write data.
REQ-011 SHALL have port ack  output  NR_OF_CLIENTS_P  one-cycle completion pulse to the granted client.
REQ-012 SHALL have port rsp_rdata  output  MEM_DATA_WIDTH_P  read data, valid in the ack cycle of a read.
REQ-013 SHALL have port sr_resp_err  output  1  sticky flag, set on any bresp/rresp != 0.
REQ-014 SHALL have port mc  axi4_if.master  -  single-beat AXI4 master toward the memory controller.

Function
REQ-015 SHALL drive awlen/arlen=0, awsize/arsize=$clog2(MEM_DATA_WIDTH_P/8), awburst/arburst=INCR, wstrb all-ones, wlast=1, bready=1.
REQ-016 SHALL implement FSM: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
REQ-017 In IDLE with any req high, SHALL grant the first requesting client at or after rr_ptr (wrap at NR_OF_CLIENTS_P-1 to 0), latching its addr, wdata, direction and index.
REQ-018 On a write grant, SHALL assert awvalid and wvalid together the next cycle and enter WR_ADDR_DATA.
REQ-019 In WR_ADDR_DATA, SHALL drop awvalid on its own awready and wvalid on its own wready independently, entering WR_RESP when both handshakes are complete, including same-cycle completion.
REQ-020 In WR_RESP on bvalid, SHALL pulse ack[granted] one cycle and return to IDLE.
REQ-021 On a read grant, SHALL assert arvalid the next cycle and enter RD_ADDR; on arready, SHALL drop arvalid, raise rready and enter RD_DATA.
REQ-022 In RD_DATA on rvalid, SHALL register rdata into rsp_rdata, drop rready, pulse ack[granted] in the same cycle the data is presented, and return to IDLE.
REQ-023 On completion, SHALL set rr_ptr to granted index + 1, wrapping to 0.
REQ-024 SHALL keep at most one AXI transaction outstanding; minimum request-to-ack latency is 3 cycles with zero-wait memory.
REQ-025 SHALL ignore req changes of the granted client after grant; requests from other clients wait without loss.
REQ-026 SHALL hold rsp_rdata stable until the next read completion.
REQ-027 SHALL set sr_resp_err when bresp or rresp is nonzero in its valid cycle and still complete the transaction normally; sr_resp_err clears only on reset.
REQ-028 SHALL never assert ack to more than one client per cycle, and never assert ack while in IDLE.

Reset
REQ-029 While rst_n is low, SHALL force state IDLE, rr_ptr=0, ack=0, rsp_rdata=0, sr_resp_err=0, awvalid=wvalid=arvalid=rready=0, awaddr=araddr=0, wdata=0.
REQ-030 Reset asserted mid-transaction SHALL abort it immediately, with no ack issued; after release, the first grant goes to the lowest-index requester.

Verification
REQ-031 Client 0 write, addr 0x100, zero-wait memory -> awvalid/wvalid in cycle 1, bvalid cycle 2, ack[0] pulse cycle 3.
REQ-032 Client 1 read, addr 0x40, rdata 0xDEAD_BEEF, rvalid delayed 5 cycles -> ack[1] with rsp_rdata=0xDEAD_BEEF in the same cycle.
REQ-033 Clients 0 and 1 both hold req continuously -> grants alternate 0,1,0,1, with no client granted twice consecutively.
REQ-034 wready returns 3 cycles before awready -> wvalid drops first, then awvalid; exactly one AW and one W beat, single ack.
REQ-035 bresp=2'b10 on a write -> ack still pulses and sr_resp_err rises and stays high until reset.
REQ-036 rst_n pulsed low during RD_DATA -> all valids low, no ack; after release, pending req[0] is granted first.

Source files
------------

// File: rtl/delay_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_if
//  Purpose  : Single-beat-capable AXI4 bundle between a master and a memory
//             controller, with master and slave views.
//  Revision : 1.0 - initial release
// ============================================================================
interface axi4_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int ID_W   = 4
);
  // Write address channel
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  // Write data channel
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  // Write response channel
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  // Read address channel
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  // Read data channel
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface
`default_nettype wire

// File: rtl/delay_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : delay_mem_arbiter
//  Purpose  : Round-robin arbiter funnelling single-beat read/write requests
//             from several delay-line cores onto one AXI4 master port, with
//             one transaction outstanding at a time.
//  Revision : 1.0 - initial release
// ============================================================================
module delay_mem_arbiter #(
  parameter int NR_OF_CLIENTS_P  = 2,
  parameter int MEM_ADDR_WIDTH_P = 32,
  parameter int MEM_DATA_WIDTH_P = 128,
  parameter int AXI4_ID_P        = 0,
  parameter int AXI4_ID_WIDTH_P  = 4
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [NR_OF_CLIENTS_P-1:0]                        req,
  input  logic [NR_OF_CLIENTS_P-1:0]                        req_wr,
  input  logic [NR_OF_CLIENTS_P-1:0][MEM_ADDR_WIDTH_P-1:0]  req_addr,
  input  logic [NR_OF_CLIENTS_P-1:0][MEM_DATA_WIDTH_P-1:0]  req_wdata,
  output logic [NR_OF_CLIENTS_P-1:0]                        ack,
  output logic [MEM_DATA_WIDTH_P-1:0]                       rsp_rdata,
  output logic                                              sr_resp_err,
  axi4_if.master                                            mc
);

  localparam int                     IDX_W_C    = $clog2(NR_OF_CLIENTS_P);
  localparam logic [IDX_W_C:0]       NR_C       = (IDX_W_C+1)'(NR_OF_CLIENTS_P);
  localparam logic [IDX_W_C-1:0]     LAST_IDX_C = IDX_W_C'(NR_OF_CLIENTS_P - 1);
  localparam logic [2:0]             SIZE_C     = 3'($clog2(MEM_DATA_WIDTH_P/8));
  localparam logic [1:0]             INCR_C     = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4
  } state_t;

  state_t                        state_q;
  logic [IDX_W_C-1:0]            rr_ptr_q;
  logic [IDX_W_C-1:0]            idx_q;
  logic [MEM_ADDR_WIDTH_P-1:0]   addr_q;
  logic [MEM_DATA_WIDTH_P-1:0]   wdata_q;
  logic [MEM_DATA_WIDTH_P-1:0]   rdata_q;
  logic [NR_OF_CLIENTS_P-1:0]    ack_q;
  logic                          err_q;
  logic                          awvalid_q;
  logic                          wvalid_q;
  logic                          arvalid_q;
  logic                          rready_q;

  logic                          grant_vld_d;
  logic [IDX_W_C-1:0]            grant_idx_d;
  logic [IDX_W_C-1:0]            rr_ptr_d;
  logic [IDX_W_C:0]              cand;
  logic                          aw_done;
  logic                          w_done;

  // Pick the first requester at or after rr_ptr, wrapping past the last client
  always_comb begin
    grant_vld_d = 1'b0;
    grant_idx_d = '0;
    cand        = '0;
    for (int i = 0; i < NR_OF_CLIENTS_P; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W_C+1)'(i);
      if (cand >= NR_C) begin
        cand = cand - NR_C;
      end
      if (!grant_vld_d && req[cand[IDX_W_C-1:0]]) begin
        grant_vld_d = 1'b1;
        grant_idx_d = cand[IDX_W_C-1:0];
      end
    end
  end

  // Pointer value after the current client completes
  assign rr_ptr_d = (idx_q == LAST_IDX_C) ? '0 : idx_q + 1'b1;

  // A write channel is finished once its valid is gone or handshakes this cycle
  assign aw_done = !awvalid_q || mc.awready;
  assign w_done  = !wvalid_q  || mc.wready;

  // Arbitration and AXI sequencing; every output is registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          // The ack cycle is skipped so the client just acked cannot be regranted
          // on the request it is still holding.
          if (grant_vld_d && (ack_q == '0)) begin
            idx_q  <= grant_idx_d;
            addr_q <= req_addr[grant_idx_d];
            if (req_wr[grant_idx_d]) begin
              wdata_q   <= req_wdata[grant_idx_d];
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR_ADDR_DATA;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_ADDR;
            end
          end
        end
        ST_WR_ADDR_DATA: begin
          if (awvalid_q && mc.awready) awvalid_q <= 1'b0;
          if (wvalid_q && mc.wready)   wvalid_q  <= 1'b0;
          if (aw_done && w_done)       state_q   <= ST_WR_RESP;
        end
        ST_WR_RESP: begin
          if (mc.bvalid) begin
            ack_q[idx_q] <= 1'b1;
            if (mc.bresp != 2'b00) err_q <= 1'b1;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          if (mc.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (mc.rvalid) begin
            rdata_q      <= mc.rdata;
            rready_q     <= 1'b0;
            ack_q[idx_q] <= 1'b1;
            if (mc.rresp != 2'b00) err_q <= 1'b1;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign rsp_rdata   = rdata_q;
  assign sr_resp_err = err_q;

  assign mc.awid     = AXI4_ID_WIDTH_P'(AXI4_ID_P);
  assign mc.awaddr   = addr_q;
  assign mc.awlen    = 8'd0;
  assign mc.awsize   = SIZE_C;
  assign mc.awburst  = INCR_C;
  assign mc.awvalid  = awvalid_q;
  assign mc.wdata    = wdata_q;
  assign mc.wstrb    = '1;
  assign mc.wlast    = 1'b1;
  assign mc.wvalid   = wvalid_q;
  assign mc.bready   = 1'b1;
  assign mc.arid     = AXI4_ID_WIDTH_P'(AXI4_ID_P);
  assign mc.araddr   = addr_q;
  assign mc.arlen    = 8'd0;
  assign mc.arsize   = SIZE_C;
  assign mc.arburst  = INCR_C;
  assign mc.arvalid  = arvalid_q;
  assign mc.rready   = rready_q;

  // IDs and rlast carry no information for single-beat, single-outstanding traffic
  logic unused_ok;
  assign unused_ok = ^{mc.bid, mc.rid, mc.rlast};

endmodule
`default_nettype wire
